// File: rtl/btc_dec_comp_code_sched.sv
// Half-iteration scheduler for the BTC component-code decoders.
// Walks the line memory row-wise or column-wise for each half-iteration,
// presenting one beat (address, lane valid, shortening mask, strobes, alpha)
// at a time under a valid/ready handshake, and waits for decoder drain
// (idec_done) before switching to the next half-iteration.
// Ports:
//   iclk, ireset (sync, active high), iclkena (freezes all state when low)
//   istart, inrows, incols, ishort, initer, ialpha0, ialpha_step : run config
//   irdy : downstream accepts current beat;  idec_done : drain pulse
//   orow_mode, oaddr, oval, osmask, ostrb {sof,sop,eop,eof}, oalpha, ohalf
//   obusy, odone : run status
module btc_dec_comp_code_sched #(
    parameter int unsigned pDEC_NUM = 8,
    parameter int unsigned pDIM_W   = 6,
    parameter int unsigned pADDR_W  = 10,
    parameter int unsigned pITER_W  = 4,
    parameter int unsigned pALPHA_W = 4
) (
    input  logic                 iclk,
    input  logic                 ireset,
    input  logic                 iclkena,
    input  logic                 istart,
    input  logic [pDIM_W-1:0]    inrows,
    input  logic [pDIM_W-1:0]    incols,
    input  logic [pDIM_W-1:0]    ishort,
    input  logic [pITER_W-1:0]   initer,
    input  logic [pALPHA_W-1:0]  ialpha0,
    input  logic [pALPHA_W-1:0]  ialpha_step,
    input  logic                 irdy,
    input  logic                 idec_done,
    output logic                 orow_mode,
    output logic [pADDR_W-1:0]   oaddr,
    output logic [pDEC_NUM-1:0]  oval,
    output logic [pDEC_NUM-1:0]  osmask,
    output logic [3:0]           ostrb,
    output logic [pALPHA_W-1:0]  oalpha,
    output logic [pITER_W:0]     ohalf,
    output logic                 obusy,
    output logic                 odone
);
    localparam int unsigned LANE_W = $clog2(pDEC_NUM);
    localparam int unsigned COL_W  = pDIM_W + LANE_W;
    localparam int unsigned HALF_W = pITER_W + 1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [pDIM_W-1:0]  DIM_ONE  = pDIM_W'(1);
    localparam logic [pADDR_W-1:0] ADDR_ONE = pADDR_W'(1);
    localparam logic [HALF_W-1:0]  HALF_ONE = HALF_W'(1);

    logic [2:0]           state_q, state_d;
    logic [pDIM_W-1:0]    nrows_q, nrows_d, ncols_q, ncols_d, nshort_q, nshort_d;
    logic [pDIM_W-1:0]    ngrp_q, ngrp_d;
    logic [pITER_W-1:0]   niter_q, niter_d;
    logic [pALPHA_W-1:0]  step_q, step_d;
    logic [pDIM_W-1:0]    r_q, r_d, g_q, g_d;
    logic                 row_q, row_d;
    logic [pADDR_W-1:0]   addr_q, addr_d;
    logic [pDEC_NUM-1:0]  val_q, val_d, smask_q, smask_d;
    logic [3:0]           strb_q, strb_d;
    logic [pALPHA_W-1:0]  alpha_q, alpha_d;
    logic [HALF_W-1:0]    half_q, half_d;
    logic                 busy_q, busy_d, done_q, done_d;

    // Active configuration: raw inputs while latching in SETUP, registers after.
    logic [pDIM_W-1:0]    cfg_rows, cfg_cols, cfg_short, cfg_ngrp, ngrp_c;
    logic [COL_W-1:0]     gsum_c;

    always_comb begin : cfg_select
        cfg_rows  = nrows_q;
        cfg_cols  = ncols_q;
        cfg_short = nshort_q;
        if (state_q == ST_SETUP) begin
            cfg_rows  = inrows;
            cfg_cols  = incols;
            cfg_short = ishort;
        end
        gsum_c   = COL_W'(cfg_cols) + COL_W'(pDEC_NUM - 1);
        ngrp_c   = pDIM_W'(gsum_c >> LANE_W);
        cfg_ngrp = (state_q == ST_SETUP) ? ngrp_c : ngrp_q;
    end

    // Position of the next beat to present, computed incrementally (no multiply).
    logic                 accept_c, last_c, load_c, cfg_zero_c, final_half_c;
    logic [pDIM_W-1:0]    bt_r, bt_g;
    logic                 bt_row;
    logic [pADDR_W-1:0]   bt_addr;

    always_comb begin : next_pos
        accept_c     = (state_q == ST_RUN) && (|val_q) && irdy;
        last_c       = (r_q == nrows_q - DIM_ONE) && (g_q == ngrp_q - DIM_ONE);
        cfg_zero_c   = (inrows == '0) || (incols == '0) || (initer == '0);
        final_half_c = (half_q + HALF_ONE) == {niter_q, 1'b0};
        load_c  = 1'b0;
        bt_r    = '0;
        bt_g    = '0;
        bt_row  = row_q;
        bt_addr = '0;
        case (state_q)
            ST_SETUP: begin
                load_c = !cfg_zero_c;
                bt_row = 1'b1;
            end
            ST_RUN: begin
                if (accept_c && !last_c) begin
                    load_c = 1'b1;
                    if (row_q) begin
                        bt_addr = addr_q + ADDR_ONE;
                        if (g_q == ngrp_q - DIM_ONE) begin
                            bt_r = r_q + DIM_ONE;
                        end else begin
                            bt_r = r_q;
                            bt_g = g_q + DIM_ONE;
                        end
                    end else if (r_q == nrows_q - DIM_ONE) begin
                        // column finished: restart at row 0 of the next group
                        bt_g    = g_q + DIM_ONE;
                        bt_addr = pADDR_W'(g_q) + ADDR_ONE;
                    end else begin
                        bt_r    = r_q + DIM_ONE;
                        bt_g    = g_q;
                        bt_addr = addr_q + pADDR_W'(ngrp_q);
                    end
                end
            end
            ST_WAIT: begin
                if (idec_done && !final_half_c) begin
                    load_c = 1'b1;
                    bt_row = ~row_q;
                end
            end
            default: ;
        endcase
    end

    // Lane valid / shortening mask / strobes for the beat at (bt_r, bt_g).
    logic [pDEC_NUM-1:0]  val_c, smask_c;
    logic [3:0]           strb_c;
    logic [COL_W-1:0]     col_c;
    logic                 r_short_c, g_first_c, g_last_c, r_first_c, r_last_c;

    always_comb begin : beat_decode
        val_c     = '0;
        smask_c   = '0;
        col_c     = '0;
        r_short_c = bt_r < cfg_short;
        for (int k = 0; k < pDEC_NUM; k++) begin
            col_c      = {bt_g, LANE_W'(k)};
            val_c[k]   = col_c < COL_W'(cfg_cols);
            smask_c[k] = val_c[k] && (r_short_c || (col_c < COL_W'(cfg_short)));
        end
        g_first_c = (bt_g == '0);
        g_last_c  = (bt_g == cfg_ngrp - DIM_ONE);
        r_first_c = (bt_r == '0);
        r_last_c  = (bt_r == cfg_rows - DIM_ONE);
        strb_c = {g_first_c && r_first_c,
                  bt_row ? g_first_c : r_first_c,
                  bt_row ? g_last_c  : r_last_c,
                  g_last_c && r_last_c};
    end

    logic [pALPHA_W:0] asum_c;

    always_comb begin : fsm_next
        state_d  = state_q;
        nrows_d  = nrows_q;
        ncols_d  = ncols_q;
        nshort_d = nshort_q;
        ngrp_d   = ngrp_q;
        niter_d  = niter_q;
        step_d   = step_q;
        r_d      = r_q;
        g_d      = g_q;
        row_d    = row_q;
        addr_d   = addr_q;
        val_d    = val_q;
        smask_d  = smask_q;
        strb_d   = strb_q;
        alpha_d  = alpha_q;
        half_d   = half_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        asum_c   = {1'b0, alpha_q} + {1'b0, step_q};
        if (load_c) begin
            r_d     = bt_r;
            g_d     = bt_g;
            row_d   = bt_row;
            addr_d  = bt_addr;
            val_d   = val_c;
            smask_d = smask_c;
            strb_d  = strb_c;
        end
        case (state_q)
            ST_IDLE: begin
                if (istart) begin
                    state_d = ST_SETUP;
                    busy_d  = 1'b1;
                end
            end
            ST_SETUP: begin
                nrows_d  = inrows;
                ncols_d  = incols;
                nshort_d = ishort;
                ngrp_d   = ngrp_c;
                niter_d  = initer;
                step_d   = ialpha_step;
                if (cfg_zero_c) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_RUN;
                    half_d  = '0;
                    alpha_d = ialpha0;
                end
            end
            ST_RUN: begin
                if (accept_c && last_c) begin
                    state_d = ST_WAIT;
                    val_d   = '0;
                    smask_d = '0;
                    strb_d  = '0;
                end
            end
            ST_WAIT: begin
                if (idec_done) begin
                    if (final_half_c) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        half_d  = half_q + HALF_ONE;
                        alpha_d = asum_c[pALPHA_W] ? '1 : asum_c[pALPHA_W-1:0];
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge iclk) begin : regs
        if (ireset) begin
            state_q  <= ST_IDLE;
            nrows_q  <= '0;
            ncols_q  <= '0;
            nshort_q <= '0;
            ngrp_q   <= '0;
            niter_q  <= '0;
            step_q   <= '0;
            r_q      <= '0;
            g_q      <= '0;
            row_q    <= 1'b1;
            addr_q   <= '0;
            val_q    <= '0;
            smask_q  <= '0;
            strb_q   <= '0;
            alpha_q  <= '0;
            half_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (iclkena) begin
            state_q  <= state_d;
            nrows_q  <= nrows_d;
            ncols_q  <= ncols_d;
            nshort_q <= nshort_d;
            ngrp_q   <= ngrp_d;
            niter_q  <= niter_d;
            step_q   <= step_d;
            r_q      <= r_d;
            g_q      <= g_d;
            row_q    <= row_d;
            addr_q   <= addr_d;
            val_q    <= val_d;
            smask_q  <= smask_d;
            strb_q   <= strb_d;
            alpha_q  <= alpha_d;
            half_q   <= half_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign orow_mode = row_q;
    assign oaddr     = addr_q;
    assign oval      = val_q;
    assign osmask    = smask_q;
    assign ostrb     = strb_q;
    assign oalpha    = alpha_q;
    assign ohalf     = half_q;
    assign obusy     = busy_q;
    assign odone     = done_q;

endmodule

// File: tb/tb_btc_dec_comp_code_sched.sv
// Directed bench for btc_dec_comp_code_sched: beat tables for several
// geometries, ready/clock-enable throttling, alpha schedule, reset abort
// and the zero-iteration shortcut.
module tb_btc_dec_comp_code_sched;

    logic       iclk;
    logic       ireset, iclkena, istart, irdy, idec_done;
    logic [5:0] inrows, incols, ishort;
    logic [3:0] initer, ialpha0, ialpha_step;
    logic       orow_mode;
    logic [9:0] oaddr;
    logic [7:0] oval, osmask;
    logic [3:0] ostrb, oalpha;
    logic [4:0] ohalf;
    logic       obusy, odone;

    btc_dec_comp_code_sched #(
        .pDEC_NUM(8), .pDIM_W(6), .pADDR_W(10), .pITER_W(4), .pALPHA_W(4)
    ) dut (
        .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .istart(istart),
        .inrows(inrows), .incols(incols), .ishort(ishort), .initer(initer),
        .ialpha0(ialpha0), .ialpha_step(ialpha_step), .irdy(irdy),
        .idec_done(idec_done), .orow_mode(orow_mode), .oaddr(oaddr),
        .oval(oval), .osmask(osmask), .ostrb(ostrb), .oalpha(oalpha),
        .ohalf(ohalf), .obusy(obusy), .odone(odone)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    typedef struct packed {
        logic       mode;
        logic [4:0] half;
        logic [9:0] addr;
        logic [7:0] val;
        logic [7:0] sm;
        logic [3:0] strb;
        logic [3:0] alpha;
    } beat_t;

    typedef struct {
        int rows; int cols; int nshort; int iter; int a0; int step; int first; int cnt;
    } cfg_t;

    beat_t tbl [32];
    cfg_t  cfgs [4];
    beat_t cap [$];
    int    total = 0;
    int    bad   = 0;

    function automatic beat_t mk(input logic m, input logic [4:0] h, input logic [9:0] a,
                                 input logic [7:0] v, input logic [7:0] s,
                                 input logic [3:0] st, input logic [3:0] al);
        beat_t b;
        b = '{m, h, a, v, s, st, al};
        return b;
    endfunction

    function automatic beat_t cur();
        beat_t b;
        b = '{orow_mode, ohalf, oaddr, oval, osmask, ostrb, oalpha};
        return b;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    // Run one configured job, capturing every accepted beat.
    task automatic run(input int ci, input bit rnd);
        bit    done_seen, waiting, hold_pend, restarted;
        int    wcnt;
        beat_t snap;
        cap.delete();
        inrows      = 6'(cfgs[ci].rows);
        incols      = 6'(cfgs[ci].cols);
        ishort      = 6'(cfgs[ci].nshort);
        initer      = 4'(cfgs[ci].iter);
        ialpha0     = 4'(cfgs[ci].a0);
        ialpha_step = 4'(cfgs[ci].step);
        irdy = 1'b1; iclkena = 1'b1; idec_done = 1'b0;
        istart = 1'b1;
        tick();
        istart = 1'b0;
        done_seen = 0; waiting = 0; hold_pend = 0; restarted = 0; wcnt = 0;
        snap = '0;
        for (int cyc = 0; cyc < 3000 && !done_seen; cyc++) begin
            if (hold_pend) chk("hold", 64'(cur()), 64'(snap));
            istart = 1'b0;
            idec_done = 1'b0;
            if (odone) begin
                done_seen = 1;
            end else begin
                irdy    = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
                iclkena = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                if (waiting) begin
                    wcnt++;
                    if (wcnt >= 3) begin
                        idec_done = 1'b1;
                        iclkena   = 1'b1;
                        waiting   = 0;
                    end
                end
                if (oval != 0 && irdy && iclkena) begin
                    cap.push_back(cur());
                    if (ostrb[0]) begin
                        waiting = 1;
                        wcnt    = 0;
                    end
                end
                // istart mid-run must be ignored
                if (cap.size() == 3 && !restarted) begin
                    istart    = 1'b1;
                    restarted = 1;
                end
                hold_pend = (oval != 0) && !(irdy && iclkena);
                snap = cur();
                tick();
            end
        end
        chk("run_timeout", 64'(done_seen), 64'(1));
        irdy = 1'b1; iclkena = 1'b1; istart = 1'b0; idec_done = 1'b0;
        tick();
        chk("busy_drop", 64'({obusy, odone}), 64'(0));
    endtask

    task automatic cmp_tbl(input int ci, input string nm);
        chk({nm, "_count"}, 64'(cap.size()), 64'(cfgs[ci].cnt));
        for (int i = 0; i < cfgs[ci].cnt && i < cap.size(); i++)
            chk(nm, 64'(cap[i]), 64'(tbl[cfgs[ci].first + i]));
    endtask

    initial begin
        logic [3:0] alpha5 [6];
        bit found, seen, anyd;

        // 4x16 grid, two groups per row
        tbl[0]  = mk(1, 0, 0, 8'hFF, 8'h00, 4'b1100, 5);
        tbl[1]  = mk(1, 0, 1, 8'hFF, 8'h00, 4'b0010, 5);
        tbl[2]  = mk(1, 0, 2, 8'hFF, 8'h00, 4'b0100, 5);
        tbl[3]  = mk(1, 0, 3, 8'hFF, 8'h00, 4'b0010, 5);
        tbl[4]  = mk(1, 0, 4, 8'hFF, 8'h00, 4'b0100, 5);
        tbl[5]  = mk(1, 0, 5, 8'hFF, 8'h00, 4'b0010, 5);
        tbl[6]  = mk(1, 0, 6, 8'hFF, 8'h00, 4'b0100, 5);
        tbl[7]  = mk(1, 0, 7, 8'hFF, 8'h00, 4'b0011, 5);
        tbl[8]  = mk(0, 1, 0, 8'hFF, 8'h00, 4'b1100, 8);
        tbl[9]  = mk(0, 1, 2, 8'hFF, 8'h00, 4'b0000, 8);
        tbl[10] = mk(0, 1, 4, 8'hFF, 8'h00, 4'b0000, 8);
        tbl[11] = mk(0, 1, 6, 8'hFF, 8'h00, 4'b0010, 8);
        tbl[12] = mk(0, 1, 1, 8'hFF, 8'h00, 4'b0100, 8);
        tbl[13] = mk(0, 1, 3, 8'hFF, 8'h00, 4'b0000, 8);
        tbl[14] = mk(0, 1, 5, 8'hFF, 8'h00, 4'b0000, 8);
        tbl[15] = mk(0, 1, 7, 8'hFF, 8'h00, 4'b0011, 8);
        // 2x13 grid, partial last group
        tbl[16] = mk(1, 0, 0, 8'hFF, 8'h00, 4'b1100, 0);
        tbl[17] = mk(1, 0, 1, 8'h1F, 8'h00, 4'b0010, 0);
        tbl[18] = mk(1, 0, 2, 8'hFF, 8'h00, 4'b0100, 0);
        tbl[19] = mk(1, 0, 3, 8'h1F, 8'h00, 4'b0011, 0);
        tbl[20] = mk(0, 1, 0, 8'hFF, 8'h00, 4'b1100, 0);
        tbl[21] = mk(0, 1, 2, 8'hFF, 8'h00, 4'b0010, 0);
        tbl[22] = mk(0, 1, 1, 8'h1F, 8'h00, 4'b0100, 0);
        tbl[23] = mk(0, 1, 3, 8'h1F, 8'h00, 4'b0011, 0);
        // 4x8 grid, shortening 3
        tbl[24] = mk(1, 0, 0, 8'hFF, 8'hFF, 4'b1110, 0);
        tbl[25] = mk(1, 0, 1, 8'hFF, 8'hFF, 4'b0110, 0);
        tbl[26] = mk(1, 0, 2, 8'hFF, 8'hFF, 4'b0110, 0);
        tbl[27] = mk(1, 0, 3, 8'hFF, 8'h07, 4'b0111, 0);
        tbl[28] = mk(0, 1, 0, 8'hFF, 8'hFF, 4'b1100, 0);
        tbl[29] = mk(0, 1, 1, 8'hFF, 8'hFF, 4'b0000, 0);
        tbl[30] = mk(0, 1, 2, 8'hFF, 8'hFF, 4'b0000, 0);
        tbl[31] = mk(0, 1, 3, 8'hFF, 8'h07, 4'b0011, 0);

        cfgs[0] = '{4, 16, 0, 1, 5, 3, 0, 16};
        cfgs[1] = '{2, 13, 0, 1, 0, 0, 16, 8};
        cfgs[2] = '{4, 8, 3, 1, 0, 0, 24, 8};
        cfgs[3] = '{1, 8, 0, 3, 12, 2, 0, 6};
        alpha5[0] = 4'd12; alpha5[1] = 4'd14; alpha5[2] = 4'd15;
        alpha5[3] = 4'd15; alpha5[4] = 4'd15; alpha5[5] = 4'd15;

        ireset = 1'b1; iclkena = 1'b1; istart = 1'b0; irdy = 1'b1; idec_done = 1'b0;
        inrows = '0; incols = '0; ishort = '0; initer = '0; ialpha0 = '0; ialpha_step = '0;
        tick();
        tick();
        chk("rst_val",   64'(oval), 64'(0));
        chk("rst_strb",  64'({ostrb, osmask}), 64'(0));
        chk("rst_addr",  64'(oaddr), 64'(0));
        chk("rst_mode",  64'(orow_mode), 64'(1));
        chk("rst_alpha", 64'({oalpha, ohalf}), 64'(0));
        chk("rst_stat",  64'({obusy, odone}), 64'(0));
        ireset = 1'b0;
        tick();

        run(0, 1'b0); cmp_tbl(0, "grid4x16");
        run(0, 1'b1); cmp_tbl(0, "grid4x16_throttled");
        run(1, 1'b0); cmp_tbl(1, "grid2x13");
        run(2, 1'b0); cmp_tbl(2, "short3");
        run(3, 1'b0);
        chk("alpha_count", 64'(cap.size()), 64'(6));
        for (int i = 0; i < 6 && i < cap.size(); i++)
            chk("alpha_sched", 64'({cap[i].mode, cap[i].half, cap[i].alpha}),
                64'({(i % 2) == 0, 5'(i), alpha5[i]}));

        // reset in the middle of the column half-iteration
        inrows = 6'd4; incols = 6'd16; ishort = '0; initer = 4'd1;
        ialpha0 = '0; ialpha_step = '0; irdy = 1'b1; iclkena = 1'b1;
        istart = 1'b1;
        tick();
        istart = 1'b0;
        found = 0; seen = 0;
        for (int c = 0; c < 200 && !found; c++) begin
            idec_done = seen && (oval == 0) && obusy;
            if (oval != 0) seen = 1;
            if (oval != 0 && !orow_mode && oaddr == 10'd4) found = 1;
            else tick();
        end
        chk("mid_found", 64'(found), 64'(1));
        idec_done = 1'b0;
        ireset = 1'b1;
        tick();
        ireset = 1'b0;
        chk("mid_reset", 64'({oval, obusy, odone, orow_mode, ostrb}),
            64'({8'h00, 1'b0, 1'b0, 1'b1, 4'h0}));
        anyd = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (odone || obusy) anyd = 1;
        end
        chk("mid_quiet", 64'(anyd), 64'(0));

        // zero iterations: SETUP then DONE, no beats
        initer = 4'd0;
        istart = 1'b1;
        tick();
        istart = 1'b0;
        chk("zi_setup", 64'({obusy, odone, oval}), 64'({1'b1, 1'b0, 8'h00}));
        tick();
        chk("zi_done", 64'({obusy, odone, oval}), 64'({1'b1, 1'b1, 8'h00}));
        tick();
        chk("zi_idle", 64'({obusy, odone}), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/btc_dec_comp_code_sched.md
Name: btc_dec_comp_code_sched

Overview:
Half-iteration scheduler for the BTC component-code decoders. Per half-iteration it generates the line-memory read address, per-lane valid/shortening mask, frame/line strobes, row/col mode and scaling alpha that drive the component-code source unit. It alternates row and column half-iterations for a configured iteration count. Before each mode switch it waits for the decoders to report drain (extrinsic write-back complete).

Parameters:
pDEC_NUM, 8, parallel decoder lanes; power of 2, at least 2
pDIM_W, 6, width of row/col/shortening counts
pADDR_W, 10, line-memory address width
pITER_W, 4, iteration count width
pALPHA_W, 4, alpha width (unsigned)

Ports:
iclk  in  1  clock
ireset  in  1  synchronous active-high reset
iclkena  in  1  clock enable; all state frozen when low
istart  in  1  start pulse; sampled only in IDLE
inrows  in  pDIM_W  code rows (column code length)
incols  in  pDIM_W  code columns (row code length)
ishort  in  pDIM_W  shortened leading rows and leading columns
initer  in  pITER_W  full iterations (row + col)
ialpha0  in  pALPHA_W  alpha of half-iteration 0
ialpha_step  in  pALPHA_W  alpha increment per half-iteration
irdy  in  1  downstream accepts current beat
idec_done  in  1  pulse: decoders drained the current half-iteration
orow_mode  out  1  1 = row half-iteration
oaddr  out  pADDR_W  line-memory read address
oval  out  pDEC_NUM  per-lane valid
osmask  out  pDEC_NUM  per-lane shortening mask
ostrb  out  4  {sof, sop, eop, eof}
oalpha  out  pALPHA_W  current alpha
ohalf  out  pITER_W+1  half-iteration index
obusy  out  1  high from SETUP to DONE inclusive
odone  out  1  one-cycle pulse at completion

Behaviour:
- Reset: FSM to IDLE. oval = 0, ostrb = 0, osmask = 0, oaddr = 0, orow_mode = 1, oalpha = 0, ohalf = 0, obusy = 0, odone = 0. Reset mid-run aborts immediately with no odone.
- All outputs are registered.
- FSM states: IDLE, SETUP, RUN, WAIT, DONE.
- IDLE -> SETUP on istart. SETUP latches config and computes ngrp = (incols + pDEC_NUM - 1) >> log2(pDEC_NUM).
- SETUP -> DONE if inrows = 0, incols = 0 or initer = 0; otherwise SETUP -> RUN with h = 0, orow_mode = 1, oalpha = ialpha0.
- istart outside IDLE is ignored.
- Beat sequence in RUN for half-iteration h:
  - Row mode: for r = 0..inrows-1, for g = 0..ngrp-1.
  - Col mode: for g = 0..ngrp-1, for r = 0..inrows-1.
  - Address is r*ngrp + g in both modes, generated incrementally (no multiplier). Row mode: +1 per beat. Col mode: +ngrp per beat, reload to g+1 at group end.
- Lane k in a beat addresses column c = g*pDEC_NUM + k.
  - oval[k] = (c < incols).
  - osmask[k] = oval[k] and (r < ishort or c < ishort).
- Strobes:
  - sof on the first beat of the half-iteration; eof on the last.
  - Row mode: sop at g = 0, eop at g = ngrp-1.
  - Col mode: sop at r = 0, eop at r = inrows-1.
- Handshake: a beat is presented the cycle after entering RUN, or after the previous beat is accepted. It is accepted in a cycle where oval != 0 and irdy = 1. While irdy = 0, every output holds.
- After the eof beat is accepted, oval is cleared and the FSM enters WAIT.
- In WAIT, on idec_done:
  - If h+1 = 2*initer: go to DONE.
  - Otherwise: h increments, orow_mode toggles, oalpha = min(oalpha + ialpha_step, 2^pALPHA_W - 1) using a (pALPHA_W+1)-bit sum and saturation, then return to RUN.
- idec_done outside WAIT is ignored.
- DONE: odone = 1 for one cycle, obusy = 0 next cycle, FSM returns to IDLE.
- Latency: istart at cycle t gives SETUP at t+1 and the first beat valid at t+2.
- Address overflow (inrows*ngrp > 2^pADDR_W) is unsupported; the bench must not generate it.

Test Plan:
1. pDEC_NUM=8, inrows=4, incols=16, ishort=0, initer=1, irdy=1. Row half: addr 0..7, sop at even addr, eop at odd addr, sof at addr 0, eof at addr 7. Then idec_done. Col half: addr 0,2,4,6,1,3,5,7. odone after the second idec_done. 16 beats total, ohalf 0 then 1.
2. incols=13, inrows=2. Beats with g=1 have oval = 8'h1F; beats with g=0 have oval = 8'hFF.
3. ishort=3, incols=8, inrows=4. Rows 0-2: osmask = 8'hFF. Row 3: osmask = 8'h07.
4. irdy toggled pseudo-randomly. Every beat sequence is identical to scenario 1, outputs hold while irdy = 0, and no beat is skipped or duplicated.
5. initer=3, ialpha0=12, ialpha_step=2, pALPHA_W=4. oalpha per half-iteration = 12, 14, 15, 15, 15, 15. orow_mode alternates 1,0,1,0,1,0.
6. Reset asserted mid-col-half: next cycle is IDLE, oval = 0, obusy = 0, no odone. initer=0 gives odone two cycles after istart with no beats. istart during RUN is ignored.
